fetch_decode_regs: RTL and testbench
====================================

Name: fetch_decode_regs

Overview:
Pipeline registers on both sides of the fetch stage, plus the pipeline control logic that drives them. The F register holds the predicted PC fed back into fetch. The D register captures fetch outputs for decode. Stall/bubble decisions are computed from downstream hazard information. The block also keeps a sticky halt flag and saturating stall/bubble counters for debug.

Parameters:
RESET_PC, 64'd0, value loaded into F_predPC on reset.
CNT_W, 16, width of the stall and bubble event counters.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
f_stat  in  4  fetch status (AOK=4'b1000, HLT=4'b0100, ADR=4'b0010, INS=4'b0001)
f_icode  in  4  fetched icode
f_ifun  in  4  fetched ifun
f_rA  in  4  fetched rA
f_rB  in  4  fetched rB
f_valC  in  64  fetched constant
f_valP  in  64  fetched incremented PC
f_predPC  in  64  predicted next PC from fetch
d_srcA  in  4  decode source A (15 = none)
d_srcB  in  4  decode source B (15 = none)
E_icode  in  4  icode in execute
E_dstM  in  4  memory destination register in execute
e_Cnd  in  1  branch condition computed in execute
M_icode  in  4  icode in memory stage
W_stat  in  4  status in writeback
F_predPC  out  64  registered predicted PC, to fetch
D_stat  out  4  D register status field
D_icode  out  4  D register icode field
D_ifun  out  4  D register ifun field
D_rA  out  4  D register rA field
D_rB  out  4  D register rB field
D_valC  out  64  D register valC field
D_valP  out  64  D register valP field
F_stall  out  1  combinational stall of F
D_stall  out  1  combinational stall of D
D_bubble  out  1  combinational bubble of D
halted  out  1  sticky: non-AOK status reached writeback
stall_cnt  out  CNT_W  saturating count of F-stall cycles
bubble_cnt  out  CNT_W  saturating count of D-bubble cycles

Behaviour:
- Reset (async, rst_n=0): F_predPC=RESET_PC; D register = bubble; halted=0; both counters=0.
  - Bubble = stat AOK, icode 1 (nop), ifun 0, rA=rB=15, valC=valP=0.
- load_use = (E_icode==5 or E_icode==4'hB) and E_dstM!=15 and (E_dstM==d_srcA or E_dstM==d_srcB).
- ret_pend = 9 in any of {D_icode, E_icode, M_icode}.
- mispredict = E_icode==7 and e_Cnd==0.
- Control outputs (combinational, no latency):
  - F_stall = load_use | ret_pend.
  - D_stall = load_use.
  - D_bubble = mispredict | (ret_pend & ~load_use).
  - Outputs are not gated by halted.
- freeze = halted | (W_stat != AOK).
- F register, at each rising edge:
  - freeze or F_stall: hold.
  - otherwise: F_predPC <= f_predPC.
- D register, at each rising edge, in priority order:
  - freeze: hold.
  - D_stall: hold (stall wins if both D_stall and D_bubble are asserted).
  - D_bubble: load bubble.
  - otherwise: load the f_* fields.
- halted: set at the first edge with W_stat != AOK; cleared only by reset.
- stall_cnt: +1 on each edge where F_stall & ~freeze; saturates at all-ones, never wraps.
- bubble_cnt: +1 on each edge where D_bubble & ~D_stall & ~freeze; saturates at all-ones, never wraps.
- Reset asserted mid-stall or mid-halt: all state returns to reset values immediately. First load occurs on the first edge after rst_n rises.

Test Plan:
- Reset then release; f_predPC=10, f_icode=3, f_valC=2, no hazards → after 1 edge F_predPC=10, D_icode=3, D_valC=2, D_stat=4'b1000; counters 0.
- Load/use: E_icode=5, E_dstM=3, d_srcB=3, f_predPC=20 → F_stall=D_stall=1, D_bubble=0; F_predPC and D hold for that edge; stall_cnt=1.
- Ret in D: D_icode=9, E/M_icode=1 → F_stall=1, D_bubble=1; D_icode becomes 1 with rA=rB=15; bubble_cnt=1. Ret moving through E then M gives 3 total bubble cycles.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=1, F_stall=0; D loads bubble; F_predPC loads f_predPC.
- Halt: W_stat=4'b0100 for one cycle, then back to AOK → halted=1 from that edge onward; F/D frozen; counters stop, even with load_use active.
- CNT_W=4, load_use held 20 cycles → stall_cnt stops at 15. Pulse rst_n low mid-run → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_decode_regs_if.sv
// Bundle of fetch-stage pipeline signals: fetch outputs and downstream hazard
// information in, F/D register contents, control and debug counters out.
interface fetch_decode_regs_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       f_stat;
    logic [3:0]       f_icode;
    logic [3:0]       f_ifun;
    logic [3:0]       f_rA;
    logic [3:0]       f_rB;
    logic [63:0]      f_valC;
    logic [63:0]      f_valP;
    logic [63:0]      f_predPC;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       W_stat;

    logic [63:0]      F_predPC;
    logic [3:0]       D_stat;
    logic [3:0]       D_icode;
    logic [3:0]       D_ifun;
    logic [3:0]       D_rA;
    logic [3:0]       D_rB;
    logic [63:0]      D_valC;
    logic [63:0]      D_valP;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Pipeline-register block side.
    modport slave (
        input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_predPC,
        input  d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, W_stat,
        output F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output F_stall, D_stall, D_bubble, halted, stall_cnt, bubble_cnt
    );

    // Surrounding pipeline side.
    modport master (
        output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_predPC,
        output d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, W_stat,
        input  F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  F_stall, D_stall, D_bubble, halted, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/fetch_decode_regs.sv
// F and D pipeline registers around the fetch stage, with the stall/bubble
// control derived from downstream hazards, a sticky halt flag and saturating
// debug counters of stall and bubble cycles.
module fetch_decode_regs #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned CNT_W    = 16
) (
    input logic                clk,
    input logic                rst_n,
    fetch_decode_regs_if.slave bus
);
    localparam logic [3:0] STAT_AOK  = 4'b1000;
    localparam logic [3:0] I_NOP     = 4'h1;
    localparam logic [3:0] I_MRMOVQ  = 4'h5;
    localparam logic [3:0] I_POPQ    = 4'hB;
    localparam logic [3:0] I_JXX     = 4'h7;
    localparam logic [3:0] I_RET     = 4'h9;
    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [63:0]      f_pred_pc_q;
    logic [3:0]       d_stat_q;
    logic [3:0]       d_icode_q;
    logic [3:0]       d_ifun_q;
    logic [3:0]       d_ra_q;
    logic [3:0]       d_rb_q;
    logic [63:0]      d_valc_q;
    logic [63:0]      d_valp_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic load_use;
    logic ret_pend;
    logic mispredict;
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic freeze;

    // Hazard detection and stall/bubble decisions; not gated by halt.
    always_comb begin
        load_use   = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                     (bus.E_dstM != REG_NONE) &&
                     ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        ret_pend   = (d_icode_q == I_RET) || (bus.E_icode == I_RET) ||
                     (bus.M_icode == I_RET);
        mispredict = (bus.E_icode == I_JXX) && !bus.e_Cnd;
        f_stall    = load_use | ret_pend;
        d_stall    = load_use;
        d_bubble   = mispredict | (ret_pend & ~load_use);
        // A bad status in writeback freezes the edge on which it is first seen too.
        freeze     = halted_q | (bus.W_stat != STAT_AOK);
    end

    // F register: predicted PC fed back into fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pred_pc_q <= RESET_PC;
        end else if (!freeze && !f_stall) begin
            f_pred_pc_q <= bus.f_predPC;
        end
    end

    // D register: stall beats bubble, bubble beats a normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_stat_q  <= STAT_AOK;
            d_icode_q <= I_NOP;
            d_ifun_q  <= 4'h0;
            d_ra_q    <= REG_NONE;
            d_rb_q    <= REG_NONE;
            d_valc_q  <= 64'd0;
            d_valp_q  <= 64'd0;
        end else if (!freeze && !d_stall) begin
            if (d_bubble) begin
                d_stat_q  <= STAT_AOK;
                d_icode_q <= I_NOP;
                d_ifun_q  <= 4'h0;
                d_ra_q    <= REG_NONE;
                d_rb_q    <= REG_NONE;
                d_valc_q  <= 64'd0;
                d_valp_q  <= 64'd0;
            end else begin
                d_stat_q  <= bus.f_stat;
                d_icode_q <= bus.f_icode;
                d_ifun_q  <= bus.f_ifun;
                d_ra_q    <= bus.f_rA;
                d_rb_q    <= bus.f_rB;
                d_valc_q  <= bus.f_valC;
                d_valp_q  <= bus.f_valP;
            end
        end
    end

    // Sticky halt flag plus saturating debug counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (bus.W_stat != STAT_AOK) begin
                halted_q <= 1'b1;
            end
            if (f_stall && !freeze && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (d_bubble && !d_stall && !freeze && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.F_predPC   = f_pred_pc_q;
    assign bus.D_stat     = d_stat_q;
    assign bus.D_icode    = d_icode_q;
    assign bus.D_ifun     = d_ifun_q;
    assign bus.D_rA       = d_ra_q;
    assign bus.D_rB       = d_rb_q;
    assign bus.D_valC     = d_valc_q;
    assign bus.D_valP     = d_valp_q;
    assign bus.F_stall    = f_stall;
    assign bus.D_stall    = d_stall;
    assign bus.D_bubble   = d_bubble;
    assign bus.halted     = halted_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_fetch_decode_regs.sv
// Directed table-driven bench for fetch_decode_regs, with hand sequences for
// asynchronous reset and counter saturation.
module tb_fetch_decode_regs;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_1000;
    localparam int unsigned CNT_W    = 4;
    localparam logic [3:0]  AOK      = 4'b1000;
    localparam logic [3:0]  HLT      = 4'b0100;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    fetch_decode_regs_if #(.CNT_W(CNT_W)) bus ();

    fetch_decode_regs #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] fpc;
        logic [3:0]  ic;
        logic [3:0]  ra;
        logic [63:0] valc;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic [3:0]  eic;
        logic [3:0]  edst;
        logic        cnd;
        logic [3:0]  mic;
        logic [3:0]  wstat;
        logic        x_fstall;
        logic        x_dstall;
        logic        x_bub;
        logic [63:0] x_fpc;
        logic [3:0]  x_dic;
        logic [3:0]  x_dra;
        logic [63:0] x_dvalc;
        logic        x_halt;
        logic [3:0]  x_sc;
        logic [3:0]  x_bc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] fpc, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [63:0] valc, input logic [3:0] srca,
                         input logic [3:0] srcb, input logic [3:0] eic, input logic [3:0] edst,
                         input logic cnd, input logic [3:0] mic, input logic [3:0] wstat);
        bus.f_stat   = AOK;
        bus.f_icode  = ic;
        bus.f_ifun   = 4'h0;
        bus.f_rA     = ra;
        bus.f_rB     = 4'h3;
        bus.f_valC   = valc;
        bus.f_valP   = fpc + 64'd10;
        bus.f_predPC = fpc;
        bus.d_srcA   = srca;
        bus.d_srcB   = srcb;
        bus.E_icode  = eic;
        bus.E_dstM   = edst;
        bus.e_Cnd    = cnd;
        bus.M_icode  = mic;
        bus.W_stat   = wstat;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " F_predPC"}, bus.F_predPC, RESET_PC);
        chk({tag, " D_stat"}, {60'd0, bus.D_stat}, {60'd0, AOK});
        chk({tag, " D_icode"}, {60'd0, bus.D_icode}, 64'd1);
        chk({tag, " D_rA/rB"}, {56'd0, bus.D_rA, bus.D_rB}, 64'hFF);
        chk({tag, " D_valC/valP"}, bus.D_valC | bus.D_valP, 64'd0);
        chk({tag, " halted"}, {63'd0, bus.halted}, 64'd0);
        chk({tag, " counters"}, {56'd0, bus.stall_cnt, bus.bubble_cnt}, 64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //           fpc   ic    ra    valc   srcA  srcB  Eic   Edst  Cnd   Mic   W
        //           Fst   Dst   Bub   xFpc   xDic  xDrA  xValC halt  sc    bc
        // Plain load.
        vecs[0]  = '{64'd10, 4'h3, 4'h2, 64'd2, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK,
                     1'b0, 1'b0, 1'b0, 64'd10, 4'h3, 4'h2, 64'd2, 1'b0, 4'd0, 4'd0};
        // Load/use via srcB: F and D hold.
        vecs[1]  = '{64'd20, 4'h6, 4'h4, 64'd7, 4'hF, 4'h3, 4'h5, 4'h3, 1'b1, 4'h1, AOK,
                     1'b1, 1'b1, 1'b0, 64'd10, 4'h3, 4'h2, 64'd2, 1'b0, 4'd1, 4'd0};
        // Fetch a ret into D.
        vecs[2]  = '{64'd20, 4'h9, 4'hF, 64'd0, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK,
                     1'b0, 1'b0, 1'b0, 64'd20, 4'h9, 4'hF, 64'd0, 1'b0, 4'd1, 4'd0};
        // Ret in D: stall F, bubble D.
        vecs[3]  = '{64'd21, 4'h3, 4'h5, 64'd5, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK,
                     1'b1, 1'b0, 1'b1, 64'd20, 4'h1, 4'hF, 64'd0, 1'b0, 4'd2, 4'd1};
        // Ret in E.
        vecs[4]  = '{64'd22, 4'h3, 4'h5, 64'd5, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, AOK,
                     1'b1, 1'b0, 1'b1, 64'd20, 4'h1, 4'hF, 64'd0, 1'b0, 4'd3, 4'd2};
        // Ret in M: third bubble.
        vecs[5]  = '{64'd23, 4'h3, 4'h5, 64'd5, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, AOK,
                     1'b1, 1'b0, 1'b1, 64'd20, 4'h1, 4'hF, 64'd0, 1'b0, 4'd4, 4'd3};
        // Fetch a jump.
        vecs[6]  = '{64'd40, 4'h7, 4'hF, 64'h50, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK,
                     1'b0, 1'b0, 1'b0, 64'd40, 4'h7, 4'hF, 64'h50, 1'b0, 4'd4, 4'd3};
        // Mispredict: bubble D, F still loads.
        vecs[7]  = '{64'd41, 4'h2, 4'h1, 64'd0, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, AOK,
                     1'b0, 1'b0, 1'b1, 64'd41, 4'h1, 4'hF, 64'd0, 1'b0, 4'd4, 4'd4};
        // Load/use via srcA together with ret in M: stall wins, no bubble.
        vecs[8]  = '{64'd50, 4'h4, 4'h6, 64'd9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h9, AOK,
                     1'b1, 1'b1, 1'b0, 64'd41, 4'h1, 4'hF, 64'd0, 1'b0, 4'd5, 4'd4};
        // popq with dstM=none never matches srcA=none.
        vecs[9]  = '{64'd60, 4'h3, 4'h8, 64'h11, 4'hF, 4'hF, 4'hB, 4'hF, 1'b1, 4'h1, AOK,
                     1'b0, 1'b0, 1'b0, 64'd60, 4'h3, 4'h8, 64'h11, 1'b0, 4'd5, 4'd4};
        // Halt status in W: frozen on that same edge.
        vecs[10] = '{64'd70, 4'h5, 4'h9, 64'h22, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, HLT,
                     1'b0, 1'b0, 1'b0, 64'd60, 4'h3, 4'h8, 64'h11, 1'b1, 4'd5, 4'd4};
        // Back to AOK with load/use: control still reported, nothing counts.
        vecs[11] = '{64'd80, 4'h5, 4'h9, 64'h22, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, AOK,
                     1'b1, 1'b1, 1'b0, 64'd60, 4'h3, 4'h8, 64'h11, 1'b1, 4'd5, 4'd4};
        // Mispredict while halted: bubble reported but not taken.
        vecs[12] = '{64'd90, 4'h2, 4'h9, 64'h33, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, AOK,
                     1'b0, 1'b0, 1'b1, 64'd60, 4'h3, 4'h8, 64'h11, 1'b1, 4'd5, 4'd4};

        drive(64'd0, 4'h1, 4'hF, 64'd0, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].fpc, vecs[i].ic, vecs[i].ra, vecs[i].valc, vecs[i].srca,
                  vecs[i].srcb, vecs[i].eic, vecs[i].edst, vecs[i].cnd, vecs[i].mic,
                  vecs[i].wstat);
            #2;
            chk($sformatf("v%0d ctrl", i), {61'd0, bus.F_stall, bus.D_stall, bus.D_bubble},
                {61'd0, vecs[i].x_fstall, vecs[i].x_dstall, vecs[i].x_bub});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d F_predPC", i), bus.F_predPC, vecs[i].x_fpc);
            chk($sformatf("v%0d D_icode/rA", i), {56'd0, bus.D_icode, bus.D_rA},
                {56'd0, vecs[i].x_dic, vecs[i].x_dra});
            chk($sformatf("v%0d D_valC", i), bus.D_valC, vecs[i].x_dvalc);
            chk($sformatf("v%0d halted", i), {63'd0, bus.halted}, {63'd0, vecs[i].x_halt});
            chk($sformatf("v%0d counters", i), {56'd0, bus.stall_cnt, bus.bubble_cnt},
                {56'd0, vecs[i].x_sc, vecs[i].x_bc});
        end

        // Asynchronous reset while halted, away from any clock edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async reset mid-halt");
        @(negedge clk);
        drive(64'h30, 4'h2, 4'h7, 64'h44, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first load after reset F_predPC", bus.F_predPC, 64'h30);
        chk("first load after reset D_icode", {60'd0, bus.D_icode}, 64'd2);
        chk("first load after reset D_valP", bus.D_valP, 64'h3A);

        // Load/use held long enough to saturate the 4-bit stall counter.
        @(negedge clk);
        drive(64'h77, 4'h6, 4'h1, 64'd0, 4'h3, 4'hF, 4'hB, 4'h3, 1'b1, 4'h1, AOK);
        repeat (15) @(posedge clk);
        #1;
        chk("stall_cnt reaches 15", {60'd0, bus.stall_cnt}, 64'd15);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_cnt saturated", {60'd0, bus.stall_cnt}, 64'd15);
        chk("F_predPC held over stall", bus.F_predPC, 64'h30);
        chk("bubble_cnt idle over stall", {60'd0, bus.bubble_cnt}, 64'd0);

        // Asynchronous reset in the middle of the stall.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async reset mid-stall");
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
